simmem_resp_bank: RTL
=====================

# simmem_resp_bank

Generic, parametrised response bank for the simulated memory controller, generalising the fixed 32-entry write-response bank to any payload width, ID count and capacity, with per-ID reservation. Slots are reserved when an address request is accepted. Responses from the real memory fill the oldest reserved slot of their ID and are held until the delay logic releases that ID. The bank sits between the real memory's B/R channel and the requester; one instance serves write responses and one serves read data.

## Interface
- `NumIds`, 16: number of AXI IDs.
- `IDWidth`, $clog2(NumIds): ID field width.
- `DataWidth`, 14: full message width; the ID occupies bits [IDWidth-1:0].
- `TotalCapacity`, 32: total slots, shared by all IDs.
- `SlotWidth`, $clog2(TotalCapacity): slot index width.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `rsv_valid_i`  in  1  reservation request.
- `rsv_id_i`  in  IDWidth  ID to reserve for.
- `rsv_ready_o`  out  1  a free slot exists.
- `rsv_slot_o`  out  SlotWidth  index of the slot granted on handshake.
- `in_valid_i`  in  1  response from the real memory.
- `in_data_i`  in  DataWidth  response; ID is in the low bits.
- `in_ready_o`  out  1  the ID of `in_data_i` has a reserved, unfilled slot.
- `release_en_i`  in  NumIds  per-ID output permission from the delay logic.
- `out_valid_o`  out  1  a filled, released head exists.
- `out_data_o`  out  DataWidth  head message.
- `out_ready_i`  in  1  requester accepts.

## Operation
- **Slot state.** Each slot holds `reserved`, `filled`, `next` (SlotWidth) and the data word.
- **Per-ID state.** Each ID holds `head`, `tail`, `fill_ptr` (oldest unfilled slot) and two counters, `n_rsv` and `n_unfilled`, each $clog2(TotalCapacity+1) bits wide.
- **Reserve.**
  - The granted slot is the lowest-index slot whose `reserved` bit is 0.
  - On handshake: set `reserved`, clear `filled`, and append the slot at the ID's tail (`next` of the old tail becomes the new slot).
  - If the ID list is empty, the new slot becomes both head and tail.
  - If the ID had no unfilled slot, `fill_ptr` becomes the new slot.
- **Fill.**
  - On the `in` handshake, write `in_data_i` into `fill_ptr` of ID = `in_data_i[IDWidth-1:0]` and set `filled`.
  - `fill_ptr` then advances to `next`.
  - `n_unfilled` decrements by 1.
  - A response for an ID with `n_unfilled`=0 is stalled (`in_ready_o`=0). It is never dropped.
- **Output.**
  - An ID is a candidate when `n_rsv`>0, its head is filled, and its `release_en_i` bit is 1.
  - The lowest candidate ID wins (fixed priority).
  - On handshake, the head slot is freed (`reserved`=0), head advances to `next`, and `n_rsv` decrements by 1.
- **Ordering.** Messages with the same ID leave in reservation order. There is no ordering between different IDs.

## Timing
- **Reset.** While `rst_i`=1, `rsv_ready_o`, `in_ready_o` and `out_valid_o` are 0, and `rsv_slot_o` and `out_data_o` are 0. After reset, all slots are free and `rsv_ready_o`=1.
- **Combinational paths.**
  - `rsv_slot_o` and `rsv_ready_o` are combinational from state.
  - `out_valid_o` and `out_data_o` are combinational from state and `release_en_i`.
  - `in_ready_o` is combinational from `in_data_i` ID and state.
- **Updates.** All state updates take effect at the next rising edge.
- **Minimum latency.**
  - Fill to output: 1 cycle. A slot filled in cycle N is eligible in cycle N+1.
  - Reservation to fill: 1 cycle.
- **Simultaneous reserve and output.** A slot freed by output in cycle N is not grantable until N+1. Reserve and output of the same ID in one cycle must both update the counters (net `n_rsv` change 0) and the list correctly.
- **Single-slot list.** Output of the last slot while a reserve for the same ID occurs: the new slot becomes head and tail.
- **Simultaneous fill and reserve.** Fill and reserve of the same ID with `n_unfilled`=0 is not possible. `in_ready_o` uses start-of-cycle state.
- **Full bank.** `rsv_ready_o`=0 and `rsv_slot_o` is don't-care.
- **Release de-assertion.** Dropping `release_en_i` while `out_valid_o`=1 without a handshake is legal and withdraws the candidate.
- **Reset mid-operation.** All contents are discarded the next cycle.

## Structure
- **Shared package (`simmem_pkg`).** Add `RespBankNumIds`, `WriteRespBankTotalCapacity`, `ReadDataBankTotalCapacity`, and `rdata_t`/`wresp_t` widths as instantiation parameters. The bank itself takes widths only, never structs.
- **Sub-module `simmem_lowest_one`.** A parametrised priority encoder returning the lowest set index and an any-set flag. It is used once for free-slot search and once for output arbitration.

## Test plan
- **Single ID.** Reset, reserve ID 3 twice (slots 0, 1), fill 0xA3 then 0xB3, and set `release_en_i[3]`. Required: `out_data_o` = 0xA3 then 0xB3 on consecutive cycles with `out_ready_i`=1.
- **Release gating and priority.** Reserve ID 5 then ID 2, fill both, release only ID 5. Required: only ID 5 data is output. Then release both with `out_ready_i`=1. Required: ID 2 is output before any later ID 5 message.
- **Full bank.** Make 32 reservations. Required: `rsv_ready_o`=0 after the 32nd handshake. Output one message. Required: `rsv_ready_o`=1 the next cycle and `rsv_slot_o` equals the freed index.
- **Unreserved fill.** Drive `in_valid_i` for ID 7 with no reservation. Required: `in_ready_o`=0 and no state change. Then reserve ID 7. Required: `in_ready_o`=1 the next cycle.
- **Same-cycle reserve and output.** Reserve and output ID 1 in the same cycle. Required: `n_rsv` is unchanged and the next message output is the newly reserved slot once filled.
- **Reset mid-operation.** Assert `rst_i` with 10 slots reserved. Required: `out_valid_o`=0 and all 32 slots free afterwards.

Source files
------------

// File: rtl/simmem_pkg.sv
// Shared types and sizing for the simulated memory controller.
// Response banks take plain widths derived from the structs below.
package simmem_pkg;

  localparam int unsigned RespBankNumIds = 16;
  localparam int unsigned WriteRespBankTotalCapacity = 32;
  localparam int unsigned ReadDataBankTotalCapacity = 32;
  localparam int unsigned RespIdWidth = $clog2(RespBankNumIds);

  typedef struct packed {
    logic [9:0]             rsp;
    logic [RespIdWidth-1:0] id;
  } wresp_t;

  typedef struct packed {
    logic [31:0]            data;
    logic [1:0]             rsp;
    logic                   last;
    logic [RespIdWidth-1:0] id;
  } rdata_t;

  localparam int unsigned WrespWidth = $bits(wresp_t);
  localparam int unsigned RdataWidth = $bits(rdata_t);

endpackage

// File: rtl/simmem_lowest_one.sv
// Priority encoder: index of the lowest set bit plus an any-set flag.
module simmem_lowest_one #(
  parameter int unsigned Width    = 32,
  parameter int unsigned IdxWidth = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0]    in_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        idx_o = IdxWidth'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_resp_bank.sv
// Response bank with per-ID reservation: slots form one linked list per ID,
// filled in reservation order and drained when the delay logic releases the ID.
module simmem_resp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned NumIds        = RespBankNumIds,
  parameter int unsigned IDWidth       = $clog2(NumIds),
  parameter int unsigned DataWidth     = WrespWidth,
  parameter int unsigned TotalCapacity = WriteRespBankTotalCapacity,
  parameter int unsigned SlotWidth     = $clog2(TotalCapacity)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rsv_valid_i,
  input  logic [IDWidth-1:0]   rsv_id_i,
  output logic                 rsv_ready_o,
  output logic [SlotWidth-1:0] rsv_slot_o,
  input  logic                 in_valid_i,
  input  logic [DataWidth-1:0] in_data_i,
  output logic                 in_ready_o,
  input  logic [NumIds-1:0]    release_en_i,
  output logic                 out_valid_o,
  output logic [DataWidth-1:0] out_data_o,
  input  logic                 out_ready_i
);

  localparam int unsigned CntWidth = $clog2(TotalCapacity + 1);

  typedef logic [SlotWidth-1:0] slot_t;
  typedef logic [CntWidth-1:0]  cnt_t;
  typedef logic [IDWidth-1:0]   id_t;

  logic [TotalCapacity-1:0]                reserved_q;
  logic [TotalCapacity-1:0]                filled_q;
  slot_t [TotalCapacity-1:0]               nxt_q;
  logic [TotalCapacity-1:0][DataWidth-1:0] data_q;

  slot_t [NumIds-1:0] head_q;
  slot_t [NumIds-1:0] tail_q;
  slot_t [NumIds-1:0] fill_ptr_q;
  cnt_t  [NumIds-1:0] n_rsv_q;
  cnt_t  [NumIds-1:0] n_unfilled_q;

  logic [NumIds-1:0] cand;
  slot_t free_slot;
  logic  free_any;
  id_t   out_id;
  logic  out_any;
  id_t   in_id;
  slot_t in_slot;
  slot_t out_slot;
  logic  rsv_fire;
  logic  in_fire;
  logic  out_fire;
  logic  rsv_head;
  logic  rsv_fill;

  simmem_lowest_one #(
    .Width    (TotalCapacity),
    .IdxWidth (SlotWidth)
  ) u_free (
    .in_i  (~reserved_q),
    .idx_o (free_slot),
    .any_o (free_any)
  );

  always_comb begin
    cand = '0;
    for (int i = 0; i < int'(NumIds); i++) begin
      cand[i] = (n_rsv_q[i] != '0) && filled_q[head_q[i]]
                && release_en_i[i];
    end
  end

  simmem_lowest_one #(
    .Width    (NumIds),
    .IdxWidth (IDWidth)
  ) u_arb (
    .in_i  (cand),
    .idx_o (out_id),
    .any_o (out_any)
  );

  assign in_id    = in_data_i[IDWidth-1:0];
  assign in_slot  = fill_ptr_q[in_id];
  assign out_slot = head_q[out_id];

  assign rsv_ready_o = free_any & ~rst_i;
  assign rsv_slot_o  = rst_i ? '0 : free_slot;
  assign in_ready_o  = ~rst_i & (n_unfilled_q[in_id] != '0);
  assign out_valid_o = out_any & ~rst_i;
  assign out_data_o  = rst_i ? '0 : data_q[out_slot];

  assign rsv_fire = rsv_valid_i & rsv_ready_o;
  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  // Same-ID output/fill this cycle can empty the list; the new slot then
  // becomes head or fill pointer since the old next link is stale.
  assign rsv_head = (n_rsv_q[rsv_id_i] == '0)
                  || (out_fire && (out_id == rsv_id_i)
                      && (n_rsv_q[rsv_id_i] == cnt_t'(1)));
  assign rsv_fill = (n_unfilled_q[rsv_id_i] == '0)
                  || (in_fire && (in_id == rsv_id_i)
                      && (n_unfilled_q[rsv_id_i] == cnt_t'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reserved_q   <= '0;
      filled_q     <= '0;
      n_rsv_q      <= '0;
      n_unfilled_q <= '0;
    end else begin
      if (out_fire) begin
        reserved_q[out_slot] <= 1'b0;
        head_q[out_id]       <= nxt_q[out_slot];
      end
      if (in_fire) begin
        filled_q[in_slot]  <= 1'b1;
        data_q[in_slot]    <= in_data_i;
        fill_ptr_q[in_id]  <= nxt_q[in_slot];
      end
      if (rsv_fire) begin
        reserved_q[free_slot] <= 1'b1;
        filled_q[free_slot]   <= 1'b0;
        tail_q[rsv_id_i]      <= free_slot;
        if (n_rsv_q[rsv_id_i] != '0) begin
          nxt_q[tail_q[rsv_id_i]] <= free_slot;
        end
        if (rsv_head) begin
          head_q[rsv_id_i] <= free_slot;
        end
        if (rsv_fill) begin
          fill_ptr_q[rsv_id_i] <= free_slot;
        end
      end
      for (int i = 0; i < int'(NumIds); i++) begin
        n_rsv_q[i] <= n_rsv_q[i]
          + cnt_t'(rsv_fire && (rsv_id_i == id_t'(i)))
          - cnt_t'(out_fire && (out_id == id_t'(i)));
        n_unfilled_q[i] <= n_unfilled_q[i]
          + cnt_t'(rsv_fire && (rsv_id_i == id_t'(i)))
          - cnt_t'(in_fire && (in_id == id_t'(i)));
      end
    end
  end

endmodule
